// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int unsigned KEY_W     = 4;
  localparam logic [3:0]  ROW_RESET = 4'b1110;

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Index of the lowest column pulled low; only meaningful when one is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    if (!col[0]) return 2'd0;
    if (!col[1]) return 2'd1;
    if (!col[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to all-ones so idle pulled-up lines read high.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 keypad scanner: row drive, column sync/debounce, one code per press on valid/ack.
// Build option: define KEYPAD_REPEAT_EN for auto-repeat while a key stays held.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned DEBOUNCE_CNT  = 20,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 200
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [3:0]       i_col,
  output logic [3:0]       o_row,
  output logic [KEY_W-1:0] o_key,
  output logic             o_valid,
  input  logic             i_ack,
  output logic             o_overrun
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT);
`else
  // Repeat timing is inert in this build; it folds in at zero weight.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT) + 0 * (REPEAT_DELAY + REPEAT_PERIOD);
`endif

  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [3:0]       col_sync;
  state_t           state;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] cnt;
  logic             deb_done_c;
  logic             accept_c;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (i_col),
    .q      (col_sync)
  );

  // Free-running row-slot divider.
  assign tick_c = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
  end

  assign deb_done_c = tick_c && (state == DEBOUNCE) && !col_sync[col_idx] &&
                      (cnt == CNT_W'(DEBOUNCE_CNT - 1));

  // Scan / debounce / held FSM; cnt is the press count in DEBOUNCE and release count in HELD.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      cnt     <= '0;
      o_row   <= ROW_RESET;
    end else if (tick_c) begin
      unique case (state)
        SCAN: begin
          if (col_sync != 4'hF) begin
            col_idx <= lowest_low(col_sync);
            cnt     <= CNT_W'(1);
            state   <= DEBOUNCE;
          end else begin
            row_idx <= row_idx + 2'd1;
            o_row   <= row_drive(row_idx + 2'd1);
          end
        end
        DEBOUNCE: begin
          if (!col_sync[col_idx]) begin
            if (deb_done_c) begin
              cnt   <= '0;
              state <= HELD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
            o_row   <= row_drive(row_idx + 2'd1);
            state   <= SCAN;
          end
        end
        HELD: begin
          if (col_sync[col_idx]) begin
            if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
              cnt     <= '0;
              row_idx <= row_idx + 2'd1;
              o_row   <= row_drive(row_idx + 2'd1);
              state   <= SCAN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_fire_c;

  assign rep_fire_c = tick_c && (state == HELD) && !col_sync[col_idx] &&
                      ((rep_cnt + REP_W'(1)) ==
                       (rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)));

  // Repeat timer: first fire after REPEAT_DELAY held ticks, then every REPEAT_PERIOD.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (deb_done_c) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (tick_c && (state == HELD)) begin
      if (col_sync[col_idx]) begin
        rep_cnt <= '0;
      end else if (rep_fire_c) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

  assign accept_c = deb_done_c || rep_fire_c;
`else
  assign accept_c = deb_done_c;
`endif

  // Output handshake: accept wins over a same-cycle ack; an unconsumed code blocks new ones.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      o_key     <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (accept_c) begin
      if (!o_valid || i_ack) begin
        o_key   <= {row_idx, col_idx};
        o_valid <= 1'b1;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_ack) begin
      o_valid <= 1'b0;
    end
  end

endmodule
